// File: rtl/toy_itcm_arb_pkg.sv
// Shared constants and types for the ITCM fetch arbiter.
// Widths mirror the fetch-path constants used by the icache and ROB.
package toy_itcm_arb_pkg;

    localparam int unsigned ADDR_WIDTH              = 32;
    localparam int unsigned FETCH_DATA_WIDTH        = 32;
    localparam int unsigned ICACHE_REQ_OPCODE_WIDTH = 2;
    localparam int unsigned MSHR_ENTRY_INDEX_WIDTH  = 2;
    localparam int unsigned ROB_ENTRY_ID_WIDTH      = 4;

    localparam int unsigned ITCM_ARB_ID_WIDTH =
        ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH + ROB_ENTRY_ID_WIDTH;
    localparam int unsigned ITCM_ARB_NUM_REQ   = 2;
    localparam int unsigned ITCM_ARB_RSP_DEPTH = 4;
    localparam int unsigned ITCM_ARB_IDX_WIDTH = $clog2(ITCM_ARB_NUM_REQ);

    typedef struct packed {
        logic [ITCM_ARB_IDX_WIDTH-1:0] idx;
        logic [FETCH_DATA_WIDTH-1:0]   data;
        logic [ITCM_ARB_ID_WIDTH-1:0]  entry_id;
    } itcm_arb_rsp_t;

endpackage

// File: rtl/toy_itcm_arb_if.sv
// Requester-side and ITCM-side handshake bundle for the fetch arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface toy_itcm_arb_if
    import toy_itcm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = ITCM_ARB_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = toy_itcm_arb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = ITCM_ARB_ID_WIDTH
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*ID_WIDTH-1:0]   req_entry_id;
    logic [NUM_REQ-1:0]            ack_vld;
    logic [NUM_REQ-1:0]            ack_rdy;
    logic [DATA_WIDTH-1:0]         ack_data;
    logic [ID_WIDTH-1:0]           ack_entry_id;
    logic                          mem_req_vld;
    logic                          mem_req_rdy;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic [ID_WIDTH-1:0]           mem_req_entry_id;
    logic                          mem_ack_vld;
    logic                          mem_ack_rdy;
    logic [DATA_WIDTH-1:0]         mem_ack_data;
    logic [ID_WIDTH-1:0]           mem_ack_entry_id;

    modport slave (
        input  req_vld, req_addr, req_entry_id, ack_rdy,
        input  mem_req_rdy, mem_ack_vld, mem_ack_data, mem_ack_entry_id,
        output req_rdy, ack_vld, ack_data, ack_entry_id,
        output mem_req_vld, mem_req_addr, mem_req_entry_id, mem_ack_rdy
    );

    modport master (
        output req_vld, req_addr, req_entry_id, ack_rdy,
        output mem_req_rdy, mem_ack_vld, mem_ack_data, mem_ack_entry_id,
        input  req_rdy, ack_vld, ack_data, ack_entry_id,
        input  mem_req_vld, mem_req_addr, mem_req_entry_id, mem_ack_rdy
    );

endinterface

// File: rtl/toy_itcm_arb_fifo.sv
// Synchronous FIFO with registered storage and wrap-bit pointers.
// DEPTH must be a power of two and at least 2.
module toy_itcm_arb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push, do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        count_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[PtrW-1:0]];
        do_pop   = pop_i && !empty_o;
        // A full FIFO may still accept a write when the head leaves the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/toy_itcm_arb.sv
// Round-robin arbiter sharing one ITCM fetch port among NUM_REQ requesters.
// Acks are buffered in a credit-reserved FIFO and routed back in issue order.
module toy_itcm_arb
    import toy_itcm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = ITCM_ARB_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = toy_itcm_arb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = ITCM_ARB_ID_WIDTH,
    parameter int unsigned RSP_DEPTH  = ITCM_ARB_RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    toy_itcm_arb_if.slave              bus,
    output logic [$clog2(RSP_DEPTH):0] outstanding,
    output logic                       ord_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned OutW = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [IdxW-1:0]       idx;
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   entry_id;
    } rsp_t;

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic            ord_err_q, ord_err_d;

    logic [IdxW-1:0] search_idx, grant_idx;
    logic            found, has_grant, credit_ok, issue, retire;
    logic            ack_accept;

    logic [IdxW-1:0] ord_head;
    logic            ord_full, ord_empty;
    logic [OutW-1:0] ord_count;
    rsp_t            rsp_wdata, rsp_head;
    logic            rsp_full, rsp_empty;
    logic [OutW-1:0] rsp_count;

    // Round-robin search starting from rr_q.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        found      = 1'b0;
        search_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_q) + k) % NUM_REQ;
            if (!found && bus.req_vld[cand]) begin
                found      = 1'b1;
                search_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        credit_ok            = (outstanding_q < OutW'(RSP_DEPTH));
        has_grant            = |bus.req_vld;
        grant_idx            = lock_q ? lock_idx_q : search_idx;
        bus.mem_req_vld      = credit_ok && has_grant;
        bus.mem_req_addr     = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_req_entry_id = bus.req_entry_id[int'(grant_idx)*ID_WIDTH +: ID_WIDTH];
        issue                = bus.mem_req_vld && bus.mem_req_rdy;
        bus.req_rdy          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_rdy[i] = has_grant && (grant_idx == IdxW'(i)) && credit_ok &&
                             bus.mem_req_rdy;
        end
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        if (issue) begin
            rr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (bus.mem_req_vld) begin
            // Stalled by the ITCM: pin the grant until it is taken.
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    // Acks are dropped when no request is on record for them.
    always_comb begin
        bus.mem_ack_rdy = !rsp_full;
        ack_accept      = bus.mem_ack_vld && bus.mem_ack_rdy && !ord_empty;
        ord_err_d       = ord_err_q || (bus.mem_ack_vld && ord_empty);
        rsp_wdata       = '{idx: ord_head, data: bus.mem_ack_data,
                            entry_id: bus.mem_ack_entry_id};
    end

    always_comb begin
        bus.ack_vld = '0;
        if (!rsp_empty) begin
            bus.ack_vld[rsp_head.idx] = 1'b1;
        end
        bus.ack_data     = rsp_head.data;
        bus.ack_entry_id = rsp_head.entry_id;
        retire           = !rsp_empty && bus.ack_rdy[rsp_head.idx];
        unique case ({issue, retire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        outstanding = outstanding_q;
        ord_err     = ord_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q          <= '0;
            lock_q        <= 1'b0;
            lock_idx_q    <= '0;
            outstanding_q <= '0;
            ord_err_q     <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            lock_q        <= lock_d;
            lock_idx_q    <= lock_idx_d;
            outstanding_q <= outstanding_d;
            ord_err_q     <= ord_err_d;
        end
    end

    toy_itcm_arb_fifo #(
        .WIDTH (IdxW),
        .DEPTH (RSP_DEPTH)
    ) u_ord_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .pop_i   (ack_accept),
        .wdata_i (grant_idx),
        .rdata_o (ord_head),
        .full_o  (ord_full),
        .empty_o (ord_empty),
        .count_o (ord_count)
    );

    toy_itcm_arb_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ack_accept),
        .pop_i   (retire),
        .wdata_i (rsp_wdata),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = ^{ord_full, ord_count, rsp_count};

endmodule

// File: doc/toy_itcm_arb.md
Name: toy_itcm_arb

Overview:
Round-robin arbiter that lets NUM_REQ fetch requesters (for example, icache MSHR refill and the prefetcher) share the single ITCM fetch request/ack port.
It issues one request per cycle and tracks requester order in an in-order tag FIFO. ITCM acks are buffered in a response FIFO reserved by credits, so ITCM output data is never overwritten while a requester back-pressures. Each ack is routed back to its originating requester.
Sits between the icache miss/prefetch logic and the ITCM.

Parameters:
NUM_REQ, 2, number of requesters (≥2)
ADDR_WIDTH, toy_pack ADDR_WIDTH, fetch address width
DATA_WIDTH, FETCH_DATA_WIDTH, fetch data width
ID_WIDTH, ICACHE_REQ_OPCODE_WIDTH+MSHR_ENTRY_INDEX_WIDTH+ROB_ENTRY_ID_WIDTH, opaque entry id carried through
RSP_DEPTH, 4, max outstanding requests = response FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_vld  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester request accept
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_entry_id  in  NUM_REQ*ID_WIDTH  per-requester entry id
ack_vld  out  NUM_REQ  per-requester ack valid
ack_rdy  in  NUM_REQ  per-requester ack accept
ack_data  out  DATA_WIDTH  ack data, shared by all requesters
ack_entry_id  out  ID_WIDTH  ack entry id, shared by all requesters
mem_req_vld  out  1  to ITCM
mem_req_rdy  in  1  from ITCM
mem_req_addr  out  ADDR_WIDTH  to ITCM
mem_req_entry_id  out  ID_WIDTH  to ITCM
mem_ack_vld  in  1  from ITCM
mem_ack_rdy  out  1  to ITCM
mem_ack_data  in  DATA_WIDTH  from ITCM
mem_ack_entry_id  in  ID_WIDTH  from ITCM
outstanding  out  $clog2(RSP_DEPTH)+1  issued-but-not-retired count
ord_err  out  1  sticky protocol error

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high (rst).
- Reset values: rr pointer=0, lock=0, outstanding=0, both FIFOs empty, ord_err=0. Hence ack_vld=0, mem_req_vld=0, req_rdy=0, mem_ack_rdy=1.
- Credit:
  - credit_ok = (outstanding < RSP_DEPTH).
  - issue = mem_req_vld & mem_req_rdy.
  - retire = any(ack_vld & ack_rdy).
  - outstanding: +1 on issue only, −1 on retire only, unchanged on both or neither.
- Arbitration:
  - Round-robin: search starts at rr pointer and grants the first i with req_vld[i].
  - mem_req_vld = credit_ok & |req_vld.
  - mem_req_addr and mem_req_entry_id are muxed from the granted requester.
  - req_rdy[i] = grant[i] & credit_ok & mem_req_rdy. At most one req_rdy bit is high.
  - On issue, rr pointer ← (granted+1) mod NUM_REQ.
- Grant lock:
  - If mem_req_vld & !mem_req_rdy, the grant index is registered (lock=1).
  - While locked, the grant stays fixed until issue, even if higher-priority requesters assert.
  - Requesters must hold vld and payload until rdy.
- Order FIFO (depth RSP_DEPTH, width $clog2(NUM_REQ)):
  - Pushes the granted index on issue.
  - Pops on mem_ack_vld & mem_ack_rdy.
  - The ITCM returns acks in order, so the head index is the owner of the incoming ack.
- Response FIFO (depth RSP_DEPTH, entry {idx, data, entry_id}):
  - Pushes on mem_ack_vld with {order head, mem_ack_data, mem_ack_entry_id}.
  - mem_ack_rdy = 1 while not full; it is never full by credit construction.
- Ack outputs:
  - ack_vld[i] = !rsp_empty & (head.idx==i).
  - ack_data and ack_entry_id always show the head entry.
  - Pop on ack_vld[head.idx] & ack_rdy[head.idx].
  - A blocked head blocks all other requesters' acks (in-order).
- Latency: ITCM ack to ack_vld is 1 cycle (registered FIFO, no bypass). Requests have zero added latency: req_vld to mem_req_vld is combinational.
- ord_err: set and held until reset when mem_ack_vld arrives with the order FIFO empty. The ack is dropped.
- Wrap-around: FIFO pointers carry an extra wrap bit for full/empty detection. The rr pointer wraps from NUM_REQ−1 to 0.
- Simultaneous events: push and pop of either FIFO in the same cycle are both legal when full or empty as the credit allows. With outstanding==RSP_DEPTH and a retire in the same cycle, no issue occurs that cycle; issue resumes the next cycle.
- Reset mid-operation: all state clears immediately. In-flight ITCM acks arriving after reset deassertion set ord_err. The environment must reset the ITCM together with this block.

Decomposition:
- toy_pack additions: ITCM_ARB_NUM_REQ, ITCM_ARB_RSP_DEPTH, and an itcm_arb_rsp_t struct {idx, data, entry_id}.
- Entry-id width expression: reused from the existing toy_pack constants.
- Sub-module: toy_itcm_arb_fifo, a parameterised sync FIFO (WIDTH, DEPTH, full/empty/count). It is instantiated twice: order FIFO and response FIFO.

Test Plan:
- Single request: req0 with addr 0x100, id 0x15, no contention → mem_req same cycle, outstanding=1; ITCM ack → ack_vld[0] one cycle later with id 0x15; ack_rdy=1 → outstanding=0.
- Fairness: both requesters hold vld for 6 cycles with mem_req_rdy=1 → grants 0,1,0,1,0,1.
- Credit: ack_rdy=0, RSP_DEPTH=4, continuous requests → exactly 4 issues, then mem_req_vld=0; one ack_rdy pulse → exactly one further issue.
- In-order routing: issue req1, req0, req1 → acks appear as ack_vld[1], [0], [1]; holding ack_rdy[1]=0 blocks ack_vld[0].
- Lock: mem_req_rdy=0 with req1 granted, then req0 asserts → grant stays 1 until mem_req_rdy=1.
- Reset mid-flight: 3 outstanding, pulse rst → outstanding=0, ack_vld=0; a stale mem_ack_vld → ord_err=1.
